// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer: issue captures result, busy for MULT_CYCLES/DIV_CYCLES, commit on the final busy edge.
// No internal queue: `start` is refused while busy and the hazard unit holds further mul/div ops in D.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic        IntReg,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   p_hi_q, p_hi_d;
  logic [31:0]   p_lo_q, p_lo_d;
  logic          p_wr_q, p_wr_d;

  logic        is_mul, is_div, is_md;
  logic        mul_signed, div_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, quo, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign is_mul     = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_md      = is_mul || is_div;
  assign mul_signed = (op == OP_MULT);
  assign div_signed = (op == OP_DIV);

  // Lower 64 bits of the product of sign-extended operands equal the signed product.
  assign mul_a = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign mul_b = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = mul_a * mul_b;

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign a_neg  = div_signed && a[31];
  assign b_neg  = div_signed && b[31];
  assign a_mag  = a_neg ? (32'd0 - a) : a;
  assign b_mag  = b_neg ? (32'd0 - b) : b;
  assign b_safe = (b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = rem;
    res_lo = quo;
    res_wr = (b != 32'd0);
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
    end
  end

  assign busy  = (state_q == BUSY);
  assign start = is_md && !IntReg && !busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_wr_d  = p_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_hi_d  = res_hi;
          p_lo_d  = res_lo;
          p_wr_d  = res_wr;
          cnt_d   = is_mul ? MULT_N : DIV_N;
          state_d = BUSY;
        end else if (!IntReg && op == OP_MTHI) begin
          hi_d = a;
        end else if (!IntReg && op == OP_MTLO) begin
          lo_d = a;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      p_wr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: each task drives one scenario and checks hand-computed HI/LO/busy/start values.
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  op;
  logic        IntReg;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run;
  int tests_failed;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .IntReg(IntReg),
    .a     (a),
    .b     (b),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 3'd0; IntReg = 1'b0; a = 32'd0; b = 32'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h start=%b, want 0 0 0 0", busy, hi, lo, start);
    end
  endtask

  task automatic test_mult();
    int busy_bad;
    busy_bad = 0;
    op = 3'd1; a = 32'hFFFFFFFD; b = 32'd5;
    #1;
    tests_run++;
    if (start !== 1'b1) begin
      tests_failed++;
      $display("FAIL mult_start: start=%b want 1", start);
    end
    tick();
    op = 3'd0;
    #1;
    tests_run++;
    if (start !== 1'b0) begin
      tests_failed++;
      $display("FAIL mult_start_once: start=%b want 0", start);
    end
    for (int k = 1; k <= 5; k++) begin
      if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) busy_bad++;
      if (k < 5) tick();
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("FAIL mult_busy_window: %0d bad cycles in T+1..T+5, want 0", busy_bad);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      tests_failed++;
      $display("FAIL mult_result: busy=%b hi=%h lo=%h, want 0 ffffffff fffffff1", busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    op = 3'd3; a = 32'hFFFFFFF9; b = 32'd2;
    tick();
    op = 3'd0;
    for (int k = 1; k < 10; k++) tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_busy_last: busy=%b at T+10, want 1", busy);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL div_result: busy=%b hi=%h lo=%h, want 0 ffffffff fffffffd", busy, hi, lo);
    end
    op = 3'd4; a = 32'd7; b = 32'd2;
    #1;
    tests_run++;
    if (start !== 1'b1) begin
      tests_failed++;
      $display("FAIL divu_no_bubble: start=%b at T+11, want 1", start);
    end
    tick();
    op = 3'd0;
    for (int k = 1; k < 11; k++) tick();
    tests_run++;
    if (busy !== 1'b0 || lo !== 32'd3 || hi !== 32'd1) begin
      tests_failed++;
      $display("FAIL divu_result: busy=%b hi=%h lo=%h, want 0 00000001 00000003", busy, hi, lo);
    end
  endtask

  task automatic test_div_signs();
    // 7 / -2 -> q=-3, r=1 ; 0x80000000 / -1 wraps
    op = 3'd3; a = 32'd7; b = 32'hFFFFFFFE;
    tick();
    op = 3'd0;
    for (int k = 1; k <= 10; k++) tick();
    tests_run++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      tests_failed++;
      $display("FAIL div_neg_divisor: hi=%h lo=%h, want 00000001 fffffffd", hi, lo);
    end
    op = 3'd3; a = 32'h80000000; b = 32'hFFFFFFFF;
    tick();
    op = 3'd0;
    for (int k = 1; k <= 10; k++) tick();
    tests_run++;
    if (lo !== 32'h80000000 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int busy_cycles;
    op = 3'd5; a = 32'h12345678;
    tick();
    op = 3'd6; a = 32'h9ABCDEF0;
    tests_run++;
    if (hi !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL mthi_write: hi=%h want 12345678", hi);
    end
    tick();
    tests_run++;
    if (lo !== 32'h9ABCDEF0) begin
      tests_failed++;
      $display("FAIL mtlo_write: lo=%h want 9abcdef0", lo);
    end
    op = 3'd3; a = 32'd100; b = 32'd0;
    tick();
    op = 3'd0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 50) begin
      busy_cycles++;
      tick();
    end
    tests_run++;
    if (busy_cycles != 10) begin
      tests_failed++;
      $display("FAIL divzero_busy_len: %0d busy cycles, want 10", busy_cycles);
    end
    tests_run++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      tests_failed++;
      $display("FAIL divzero_keep: hi=%h lo=%h, want 12345678 9abcdef0", hi, lo);
    end
  endtask

  task automatic test_intreg();
    op = 3'd1; a = 32'd3; b = 32'd4; IntReg = 1'b1;
    #1;
    tests_run++;
    if (start !== 1'b0) begin
      tests_failed++;
      $display("FAIL intreg_start: start=%b want 0", start);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL intreg_busy: busy=%b want 0", busy);
    end
    op = 3'd5; a = 32'hDEADBEEF;
    tick();
    tests_run++;
    if (hi !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL intreg_mthi: hi=%h want 12345678", hi);
    end
    IntReg = 1'b0; op = 3'd6; a = 32'hCAFEBABE;
    tick();
    op = 3'd0;
    tests_run++;
    if (lo !== 32'hCAFEBABE) begin
      tests_failed++;
      $display("FAIL mtlo_after_intreg: lo=%h want cafebabe", lo);
    end
  endtask

  task automatic test_reset_mid();
    op = 3'd2; a = 32'hFFFFFFFF; b = 32'd2;
    tick();
    op = 3'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
    tick(); tick();
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h at T+6, want 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_op_while_busy();
    op = 3'd1; a = 32'd3; b = 32'd4;
    tick();
    op = 3'd0;
    tick();
    op = 3'd6; a = 32'h55555555;
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_op_window: busy=%b when mtlo presented, want 1", busy);
    end else begin
      $display("[TB] protocol violation: op %0d presented while busy", op);
    end
    tick();
    op = 3'd0;
    tests_run++;
    if (lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL busy_op_ignored: lo=%h want 00000000", lo);
    end
    tick(); tick(); tick();
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
      tests_failed++;
      $display("FAIL busy_op_result: busy=%b hi=%h lo=%h, want 0 00000000 0000000c", busy, hi, lo);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; op = 3'd0; IntReg = 1'b0; a = 32'd0; b = 32'd0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_signs();
    test_div_zero();
    test_intreg();
    test_reset_mid();
    test_op_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
